// File: rtl/burst_line_memory_pkg.sv
// Shared definitions for the burst line memory: bus geometry, FSM state
// encoding and small line/address helpers used by the top and the array.
package bmem_pkg;

  localparam int BEAT_W      = 64;
  localparam int BURST_LEN   = 4;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BEATS = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RD_BEATS = 3'd3,
    ST_WR_RESP  = 3'd4
  } bmem_state_t;

  // Extract beat k (lowest beat = line bits [63:0]) from a full line.
  function automatic logic [BEAT_W-1:0] beat_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        k);
    beat_sel = line[{k, 6'd0} +: BEAT_W];
  endfunction

  // A line address must have its byte-offset bits clear.
  function automatic logic is_line_aligned(input logic [31:0] addr);
    is_line_aligned = (addr[OFFSET_BITS-1:0] == 5'd0);
  endfunction

endpackage

// File: rtl/burst_line_memory_line_array.sv
// Full-line storage: one 256-bit line per index, synchronous write of a
// whole line, combinational read of the addressed line. Contents start
// at zero and are deliberately not touched by the block reset.
module bmem_line_array
  import bmem_pkg::*;
#(
  parameter int LINE_IDX_BITS = 10
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [LINE_IDX_BITS-1:0] line_idx,
  input  logic [LINE_W-1:0]        wr_line,
  output logic [LINE_W-1:0]        rd_line
);

  localparam int DEPTH = 2 ** LINE_IDX_BITS;

  logic [LINE_W-1:0] mem_r [DEPTH] = '{default: '0};

  // Commit a complete line when the write burst has fully arrived.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[line_idx] <= wr_line;
    end
  end

  assign rd_line = mem_r[line_idx];

endmodule

// File: rtl/burst_line_memory.sv
// Main-memory model behind the cacheline adaptor. Each transaction moves
// one 256-bit line as four 64-bit beats; read beats appear LATENCY cycles
// after acceptance, a write is acknowledged by a single resp pulse
// LATENCY cycles after its last beat. Host protocol violations raise a
// sticky error flag without disturbing the transaction in flight.
module burst_line_memory
  import bmem_pkg::*;
#(
  parameter int LINE_IDX_BITS = 10,
  parameter int LATENCY       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_address,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic [63:0] bmem_rdata,
  output logic        bmem_resp,
  output logic        error
);

  bmem_state_t               state_r;
  logic [31:0]               addr_r;
  logic                      is_wr_r;
  logic [2:0]                beat_cnt_r;
  logic [15:0]               wait_cnt_r;
  logic [3*BEAT_W-1:0]       wr_buf_r;
  logic                      resp_end_r;
  logic                      resp_r;
  logic [BEAT_W-1:0]         rdata_r;
  logic                      error_r;

  logic                      wr_en_s;
  logic [LINE_W-1:0]         wr_line_s;
  logic [LINE_W-1:0]         rd_line_s;
  logic [LINE_IDX_BITS-1:0]  line_idx_s;
  logic                      viol_s;
  logic                      both_req_s;
  logic                      active_req_s;
  logic                      opp_req_s;

  // Upper address bits are ignored so addresses alias modulo the array size.
  assign line_idx_s = addr_r[OFFSET_BITS +: LINE_IDX_BITS];

  bmem_line_array #(
    .LINE_IDX_BITS (LINE_IDX_BITS)
  ) u_line_array (
    .clk      (clk),
    .wr_en    (wr_en_s),
    .line_idx (line_idx_s),
    .wr_line  (wr_line_s),
    .rd_line  (rd_line_s)
  );

  // Line commit happens on the edge that captures beat 3; a reset on that
  // same edge suppresses it so a partial line is never written.
  always_comb begin
    wr_line_s = {bmem_wdata, wr_buf_r};
    if ((state_r == ST_WR_BEATS) && (beat_cnt_r == 3'd3) && !rst) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Transaction FSM with registered resp and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      addr_r     <= 32'd0;
      is_wr_r    <= 1'b0;
      beat_cnt_r <= 3'd0;
      wait_cnt_r <= 16'd0;
      wr_buf_r   <= '0;
      resp_end_r <= 1'b0;
      resp_r     <= 1'b0;
      rdata_r    <= 64'd0;
    end else begin
      resp_end_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bmem_read && !bmem_write) begin
            addr_r     <= bmem_address;
            is_wr_r    <= 1'b0;
            beat_cnt_r <= 3'd0;
            wait_cnt_r <= 16'd0;
            state_r    <= ST_WAIT;
          end else if (bmem_write && !bmem_read) begin
            addr_r                <= bmem_address;
            is_wr_r               <= 1'b1;
            wr_buf_r[63:0]        <= bmem_wdata;
            beat_cnt_r            <= 3'd1;
            wait_cnt_r            <= 16'd0;
            state_r               <= ST_WR_BEATS;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_WR_BEATS: begin
          case (beat_cnt_r)
            3'd1: begin
              wr_buf_r[127:64] <= bmem_wdata;
              beat_cnt_r       <= 3'd2;
            end
            3'd2: begin
              wr_buf_r[191:128] <= bmem_wdata;
              beat_cnt_r        <= 3'd3;
            end
            3'd3: begin
              // beat 3 goes straight into the committed line
              beat_cnt_r <= 3'd0;
              wait_cnt_r <= 16'd0;
              state_r    <= ST_WAIT;
            end
            default: begin
              beat_cnt_r <= 3'd0;
              state_r    <= ST_IDLE;
            end
          endcase
        end

        ST_WAIT: begin
          if (wait_cnt_r == 16'(LATENCY - 1)) begin
            wait_cnt_r <= 16'd0;
            resp_r     <= 1'b1;
            if (is_wr_r) begin
              state_r <= ST_WR_RESP;
            end else begin
              rdata_r    <= beat_sel(rd_line_s, 2'd0);
              beat_cnt_r <= 3'd1;
              state_r    <= ST_RD_BEATS;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end

        ST_RD_BEATS: begin
          if (beat_cnt_r != 3'd4) begin
            rdata_r    <= beat_sel(rd_line_s, beat_cnt_r[1:0]);
            beat_cnt_r <= beat_cnt_r + 3'd1;
          end else begin
            resp_r     <= 1'b0;
            beat_cnt_r <= 3'd0;
            resp_end_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end

        ST_WR_RESP: begin
          resp_r     <= 1'b0;
          resp_end_r <= 1'b1;
          state_r    <= ST_IDLE;
        end

        default: begin
          resp_r     <= 1'b0;
          beat_cnt_r <= 3'd0;
          wait_cnt_r <= 16'd0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Classify the current cycle's host behaviour as legal or a violation.
  always_comb begin
    both_req_s = bmem_read & bmem_write;
    if (is_wr_r) begin
      active_req_s = bmem_write;
      opp_req_s    = bmem_read;
    end else begin
      active_req_s = bmem_read;
      opp_req_s    = bmem_write;
    end
    case (state_r)
      ST_IDLE: begin
        viol_s = both_req_s
               | ((bmem_read ^ bmem_write) & !is_line_aligned(bmem_address))
               | (resp_end_r & (bmem_read | bmem_write));
      end
      default: begin
        viol_s = both_req_s
               | (bmem_address != addr_r)
               | !active_req_s
               | opp_req_s;
      end
    endcase
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_r <= 1'b0;
    end else if (viol_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign bmem_resp  = resp_r;
  assign bmem_rdata = rdata_r;
  assign error      = error_r;

endmodule

// File: tb/tb_burst_line_memory.sv
// Directed bench for burst_line_memory: reset/idle, read latency and beat
// order, write/readback, aliasing, protocol errors, reset mid-write.
module tb_burst_line_memory;

  localparam int LAT = 8;

  logic        clk;
  logic        rst;
  logic [31:0] bmem_address;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic [63:0] bmem_rdata;
  logic        bmem_resp;
  logic        error;

  int checks = 0;
  int errors = 0;

  burst_line_memory #(
    .LINE_IDX_BITS (10),
    .LATENCY       (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bmem_address (bmem_address),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_rdata   (bmem_rdata),
    .bmem_resp    (bmem_resp),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_address = 32'd0;
    bmem_wdata   = 64'd0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_resp", {63'd0, bmem_resp}, 64'd0);
    chk("rst_err", {63'd0, error}, 64'd0);
  endtask

  task automatic read_line(input string tag, input logic [31:0] addr, input logic [255:0] exp);
    int n;
    step();
    bmem_address = addr;
    bmem_read    = 1'b1;
    step();
    n = 1;
    while (bmem_resp !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(LAT + 1));
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_resp"}, {63'd0, bmem_resp}, 64'd1);
      chk({tag, "_beat"}, bmem_rdata, exp[k*64 +: 64]);
      step();
    end
    bmem_read = 1'b0;
    chk({tag, "_end"}, {63'd0, bmem_resp}, 64'd0);
    chk({tag, "_hold"}, bmem_rdata, exp[255:192]);
    chk({tag, "_err"}, {63'd0, error}, 64'd0);
  endtask

  task automatic write_line(input string tag, input logic [31:0] addr, input logic [255:0] line);
    int n;
    step();
    bmem_address = addr;
    bmem_write   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bmem_wdata = line[k*64 +: 64];
      step();
    end
    n = 0;
    while (bmem_resp !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(LAT));
    step();
    bmem_write = 1'b0;
    chk({tag, "_pulse"}, {63'd0, bmem_resp}, 64'd0);
    chk({tag, "_err"}, {63'd0, error}, 64'd0);
  endtask

  logic [255:0] line_a;
  logic [255:0] line_b;
  logic [255:0] zero_line;

  initial begin
    int n;
    line_a    = {64'h4444444444444444, 64'h3333333333333333,
                 64'h2222222222222222, 64'h1111111111111111};
    line_b    = {64'hdddddddddddddddd, 64'hcccccccccccccccc,
                 64'hbbbbbbbbbbbbbbbb, 64'haaaaaaaaaaaaaaaa};
    zero_line = 256'd0;

    do_reset();
    chk("rst_rdata", bmem_rdata, 64'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_resp", {63'd0, bmem_resp}, 64'd0);
      chk("idle_rdata", bmem_rdata, 64'd0);
      chk("idle_err", {63'd0, error}, 64'd0);
    end

    // fresh memory reads as zero
    read_line("rd40_fresh", 32'h00000040, zero_line);

    // write then read back, neighbour untouched
    write_line("wr20", 32'h00000020, line_a);
    read_line("rd20", 32'h00000020, line_a);
    read_line("rd40", 32'h00000040, zero_line);

    // aliasing: bit 15 is above the 10-bit index field
    write_line("wr8020", 32'h00008020, line_b);
    read_line("rd20_alias", 32'h00000020, line_b);

    // read and write together
    step();
    bmem_address = 32'h00000040;
    bmem_read    = 1'b1;
    bmem_write   = 1'b1;
    step();
    chk("both_err", {63'd0, error}, 64'd1);
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    step();
    step();
    chk("both_sticky", {63'd0, error}, 64'd1);
    do_reset();

    // unaligned read
    step();
    bmem_address = 32'h00000024;
    bmem_read    = 1'b1;
    step();
    chk("unal_err", {63'd0, error}, 64'd1);
    step();
    chk("unal_sticky", {63'd0, error}, 64'd1);
    do_reset();

    // address changed while read beats are flowing
    step();
    bmem_address = 32'h00000040;
    bmem_read    = 1'b1;
    n = 0;
    while (bmem_resp !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("achg_pre_err", {63'd0, error}, 64'd0);
    chk("achg_resp", {63'd0, bmem_resp}, 64'd1);
    bmem_address = 32'h00000060;
    step();
    chk("achg_err", {63'd0, error}, 64'd1);
    do_reset();

    // reset while a write burst is partway in: old line must survive
    step();
    bmem_address = 32'h00000020;
    bmem_write   = 1'b1;
    bmem_wdata   = 64'h5555555555555555;
    step();
    bmem_wdata   = 64'h6666666666666666;
    step();
    rst          = 1'b1;
    bmem_write   = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_resp", {63'd0, bmem_resp}, 64'd0);
    chk("abort_err", {63'd0, error}, 64'd0);
    read_line("rd20_abort", 32'h00000020, line_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
